div_sequencer: RTL
==================

Name: div_sequencer

Overview:
- Issue/retire stage wrapped around the shared 8-bit radix-2 `divider` core in the arithmetic processor.
- Accepts divide requests over a valid/ready handshake, in signed or unsigned mode.
- Converts signed operands to magnitudes, sequences the core's load/iterate `start` protocol, captures quotient/remainder, applies sign fix-up, and returns a registered result with status flags.
- Handles divide-by-zero and signed overflow without running the core.

Parameters:
- DIV_W, 8, operand/result width; must equal the `divider` core width.
- ITER, 8, core iterations per divide (one per bit).
- WDOG, 12, RUN-state cycle limit before a response with rsp_err is forced.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_dividend  in  DIV_W  dividend
- req_divisor  in  DIV_W  divisor
- req_signed  in  1  1 = two's-complement operands
- rsp_valid  out  1  result valid; held until accepted
- rsp_ready  in  1  consumer accepts result
- rsp_quotient  out  DIV_W  quotient
- rsp_remainder  out  DIV_W  remainder
- rsp_dbz  out  1  divide by zero
- rsp_ovf  out  1  signed overflow (-2^(W-1) / -1)
- rsp_err  out  1  core watchdog expired
- div_start  out  1  to core: 0 = load operands, 1 = iterate
- div_dividend  out  DIV_W  to core: dividend magnitude (registered)
- div_divisor  out  DIV_W  to core: divisor magnitude (registered)
- div_quotient  in  DIV_W  from core
- div_remainder  in  DIV_W  from core
- div_ready  in  1  from core: iteration count reached zero

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - rsp_valid=0; rsp_quotient/rsp_remainder=0; all flags 0.
  - Operand registers=0; div_start=0.
  - Reset mid-operation abandons the divide. No result is emitted.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - req_ready=1, div_start=0. The core reloads every edge, which is harmless.
  - On req_valid: register the operand magnitudes (negate if req_signed and MSB set), the signed flag, qneg = sign(dividend) XOR sign(divisor), and rneg = sign(dividend).
  - Divisor==0 -> DONE with quotient=all-ones, remainder=raw dividend, dbz=1.
  - Signed, dividend=0x80, divisor=0xFF -> DONE with quotient=0x80, remainder=0, ovf=1.
  - Otherwise -> LOAD.
- LOAD: div_start=0 for exactly one cycle, so the core latches operands at this edge. -> RUN; clear the watchdog counter.
- RUN:
  - div_start = !div_ready (combinational), so the core never iterates past zero.
  - On an edge with div_ready=1: capture div_quotient/div_remainder.
    - Negate the quotient if signed&qneg; negate the remainder if signed&rneg.
    - -> DONE.
  - Watchdog counter increments each RUN cycle. Reaching WDOG without div_ready -> DONE with rsp_err=1 and quotient=remainder=0.
- DONE:
  - rsp_valid=1 and all rsp_* held stable until rsp_ready.
  - On the edge with rsp_ready: clear rsp_valid -> IDLE.
- Latency:
  - Normal path: accept edge at T0; rsp_valid high from T0+10 (1 LOAD + 8 iterate + 1 capture).
  - dbz/ovf path: rsp_valid high from T0+1.
  - Minimum issue period is 12 cycles.
- Arithmetic rules:
  - Negation is two's complement modulo 2^DIV_W. Magnitude of 0x80 is 0x80, which is a valid unsigned core operand.
  - In unsigned mode, operands pass through unchanged and there is no fix-up.
- Simultaneous events: req_valid while not in IDLE is ignored; req_ready=0 there.
- Back-pressure: rsp_ready low stalls indefinitely in DONE. The core is idle-loading meanwhile.

Decomposition:
- Package div_pkg holds:
  - the state enum (IDLE/LOAD/RUN/DONE)
  - DIV_W, ITER, WDOG defaults
  - DBZ_QUOTIENT (all-ones) and SMIN (0x80) constants
- One natural combinational sub-module, div_sign_fix:
  - pre-divide magnitude conversion (abs)
  - post-divide conditional negation of quotient and remainder
  - instantiated once for each use.

Test Plan:
- Unsigned 200/7 -> q=28 (0x1C), r=4; dbz/ovf/err=0; rsp_valid exactly 10 cycles after the accept edge.
- Signed -100/7 (0x9C/0x07) -> q=0xF2 (-14), r=0xFE (-2). Signed 100/-7 -> q=0xF2, r=0x02.
- 0x55/0 unsigned -> q=0xFF, r=0x55, dbz=1, rsp_valid 1 cycle after accept, core never sees div_start=1. Signed 0x80/0xFF -> q=0x80, r=0, ovf=1.
- Back-pressure: unsigned 128/255 with rsp_ready low for 5 cycles -> q=0, r=128 held stable, req_ready=0 throughout; next request accepted only after retire + IDLE.
- Reset asserted mid-RUN (cycle 4) -> rsp_valid stays 0, div_start=0 immediately. A following 9/3 request yields q=3, r=0.
- Core model with div_ready stuck at 0 -> rsp_err=1 after WDOG RUN cycles, q=r=0. Every run checks div_start is never 1 while div_ready=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divide issue/retire sequencer.
package div_pkg;

  localparam int unsigned DIV_W_DEFAULT = 8;
  localparam int unsigned ITER_DEFAULT  = 8;
  localparam int unsigned WDOG_DEFAULT  = 12;

  localparam logic [DIV_W_DEFAULT-1:0] DBZ_QUOTIENT = '1;
  localparam logic [DIV_W_DEFAULT-1:0] SMIN = {1'b1, {(DIV_W_DEFAULT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/div_if.sv
// Request/response handshake bundle between a divide client and the sequencer.
interface div_if #(parameter int unsigned W = 8);

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_dividend;
  logic [W-1:0] req_divisor;
  logic         req_signed;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_quotient;
  logic [W-1:0] rsp_remainder;
  logic         rsp_dbz;
  logic         rsp_ovf;
  logic         rsp_err;

  modport master (
    output req_valid, req_dividend, req_divisor, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, rsp_ovf, rsp_err
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, rsp_ovf, rsp_err
  );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation; serves both as abs() and as sign fix-up.
module div_sign_fix #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/div_sequencer.sv
// Issue/retire stage around the radix-2 divider core: operand prep, core
// sequencing, sign fix-up, special-case handling and a watchdog.
module div_sequencer
  import div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT,
  parameter int unsigned ITER  = ITER_DEFAULT,
  parameter int unsigned WDOG  = WDOG_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  div_if.slave             bus,
  output logic             div_start,
  output logic [DIV_W-1:0] div_dividend,
  output logic [DIV_W-1:0] div_divisor,
  input  logic [DIV_W-1:0] div_quotient,
  input  logic [DIV_W-1:0] div_remainder,
  input  logic             div_ready
);

  // Counter sized for whichever is longer, the core's iteration span or the limit.
  localparam int unsigned CNT_W = $clog2(((WDOG > ITER) ? WDOG : ITER) + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wdog;
  logic               signed_q, qneg_q, rneg_q;
  logic [DIV_W-1:0]   quo_q, rem_q;
  logic               dbz_q, ovf_q, err_q;
  logic [DIV_W-1:0]   dvd_abs, dvs_abs, quo_fix, rem_fix;
  logic               is_dbz, is_ovf, wdog_hit;

  div_sign_fix #(.W(DIV_W)) u_abs_dvd (
    .a(bus.req_dividend), .neg(bus.req_signed & bus.req_dividend[DIV_W-1]), .y(dvd_abs));
  div_sign_fix #(.W(DIV_W)) u_abs_dvs (
    .a(bus.req_divisor), .neg(bus.req_signed & bus.req_divisor[DIV_W-1]), .y(dvs_abs));
  div_sign_fix #(.W(DIV_W)) u_fix_quo (
    .a(div_quotient), .neg(signed_q & qneg_q), .y(quo_fix));
  div_sign_fix #(.W(DIV_W)) u_fix_rem (
    .a(div_remainder), .neg(signed_q & rneg_q), .y(rem_fix));

  assign is_dbz   = (bus.req_divisor == '0);
  assign is_ovf   = bus.req_signed && (bus.req_dividend == SMIN) && (bus.req_divisor == '1);
  assign wdog_hit = (wdog == CNT_W'(WDOG - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    div_start     = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = (is_dbz || is_ovf) ? DONE : LOAD;
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        div_start = !div_ready;
        if (div_ready || wdog_hit) state_nxt = DONE;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_dividend <= '0;
      div_divisor  <= '0;
      signed_q     <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      wdog         <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      dbz_q        <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          div_dividend <= dvd_abs;
          div_divisor  <= dvs_abs;
          signed_q     <= bus.req_signed;
          qneg_q       <= bus.req_dividend[DIV_W-1] ^ bus.req_divisor[DIV_W-1];
          rneg_q       <= bus.req_dividend[DIV_W-1];
          dbz_q        <= is_dbz;
          ovf_q        <= is_ovf && !is_dbz;
          err_q        <= 1'b0;
          if (is_dbz) begin
            quo_q <= DBZ_QUOTIENT;
            rem_q <= bus.req_dividend;
          end else if (is_ovf) begin
            quo_q <= SMIN;
            rem_q <= '0;
          end
        end
        LOAD: wdog <= '0;
        RUN: begin
          if (div_ready) begin
            quo_q <= quo_fix;
            rem_q <= rem_fix;
          end else if (wdog_hit) begin
            err_q <= 1'b1;
            quo_q <= '0;
            rem_q <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_quotient  = quo_q;
  assign bus.rsp_remainder = rem_q;
  assign bus.rsp_dbz       = dbz_q;
  assign bus.rsp_ovf       = ovf_q;
  assign bus.rsp_err       = err_q;

endmodule
